// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Runs one RV32M operation at a time in the execute stage and holds the
// pipeline until the result is ready.
// - Multiplies go to an external pipelined multiplier with a fixed latency.
// - Divides and remainders go to a handshaked divider core, which is cleared
//   immediately before each launch.
// - Divide-by-zero and signed overflow are answered directly, without the
//   divider.
//
// Ports
//   clk, resetn                   clock, asynchronous active-low reset
//   op_valid, op_funct3           M-type op present in EX and its funct3
//   op_a, op_b                    rs1 / rs2 values
//   flush                         kill the in-flight op
//   stall                         freeze IF/ID/EX (combinational)
//   result_valid, result          one-cycle retire strobe and rd value
//   mul_a, mul_b                  33-bit extended operands to the multiplier
//   mul_p                         66-bit product, MUL_LATENCY cycles later
//   div_aresetn                   divider core clear, active-low
//   div_in_valid                  divider launch pulse
//   div_dividend, div_divisor     divider operands
//   div_signed                    1 for DIV/REM
//   div_out_valid                 divider result strobe
//   div_quotient, div_remainder   divider results
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op_funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [32:0] mul_a,
    output logic [32:0] mul_b,
    input  logic [65:0] mul_p,
    output logic        div_aresetn,
    output logic        div_in_valid,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    output logic        div_signed,
    input  logic        div_out_valid,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = (MUL_LATENCY < 1) ? 1 : $clog2(MUL_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        MUL_WAIT,
        DIV_CLR,
        DIV_RUN,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic [DATA_W-1:0]   result_r, result_nxt;
    logic [DATA_W-1:0]   opa_r, opb_r;
    logic [2:0]          f3_r;
    logic                load_ops;
    logic                div_aresetn_r, div_aresetn_nxt;
    logic                div_in_valid_r, div_in_valid_nxt;
    logic                unused_mul_hi;

    // Signed overflow only exists for the signed divide ops (DIV, REM).
    function automatic logic is_signed_ovf(input logic [2:0] f3,
                                           input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b);
        return ((f3 == 3'b100) || (f3 == 3'b110)) &&
               (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // Architectural results for the cases that bypass the divider.
    function automatic logic [DATA_W-1:0] special_div_result(input logic [2:0] f3,
                                                             input logic [DATA_W-1:0] a,
                                                             input logic [DATA_W-1:0] b);
        if (b == '0)
            return f3[1] ? a : 32'hFFFF_FFFF;
        else
            return f3[1] ? 32'h0000_0000 : 32'h8000_0000;
    endfunction

    function automatic logic [DATA_W:0] ext33(input logic [DATA_W-1:0] v,
                                              input logic sgn);
        return {sgn & v[DATA_W-1], v};
    endfunction

    // Multiplier operands: rs1 signed for MULH/MULHSU, rs2 signed only for MULH.
    assign mul_a = ext33(opa_r, (f3_r[1:0] == 2'b01) || (f3_r[1:0] == 2'b10));
    assign mul_b = ext33(opb_r, (f3_r[1:0] == 2'b01));

    assign div_dividend = opa_r;
    assign div_divisor  = opb_r;
    assign div_signed   = ~f3_r[0];
    assign div_aresetn  = div_aresetn_r;
    assign div_in_valid = div_in_valid_r;
    assign result       = result_r;

    // Product bits above 63 carry no RV32M result.
    assign unused_mul_hi = ^mul_p[65:64];

    // A flush drops stall and the retire strobe in the same cycle.
    assign stall = ~flush & (((state == IDLE) & op_valid) |
                             (state == MUL_WAIT) |
                             (state == DIV_CLR)  |
                             (state == DIV_RUN));
    assign result_valid = (state == DONE) & ~flush;

    always_comb begin
        state_nxt        = state;
        count_nxt        = count;
        result_nxt       = result_r;
        load_ops         = 1'b0;
        div_aresetn_nxt  = 1'b1;
        div_in_valid_nxt = 1'b0;

        if (flush) begin
            state_nxt = IDLE;
            // A divide may already be running in the core; clear it so a
            // stale strobe cannot leak into the next op.
            if ((state == DIV_CLR) || (state == DIV_RUN))
                div_aresetn_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_valid) begin
                        load_ops = 1'b1;
                        if (!op_funct3[2]) begin
                            state_nxt = MUL_WAIT;
                            count_nxt = CNT_LOAD;
                        end else if ((op_b == '0) || is_signed_ovf(op_funct3, op_a, op_b)) begin
                            state_nxt  = DONE;
                            result_nxt = special_div_result(op_funct3, op_a, op_b);
                        end else begin
                            state_nxt       = DIV_CLR;
                            div_aresetn_nxt = 1'b0;
                        end
                    end
                end
                MUL_WAIT: begin
                    if (count == '0) begin
                        result_nxt = (f3_r[1:0] == 2'b00) ? mul_p[31:0] : mul_p[63:32];
                        state_nxt  = DONE;
                    end else begin
                        count_nxt = count - CNT_W'(1);
                    end
                end
                DIV_CLR: begin
                    state_nxt        = DIV_RUN;
                    div_in_valid_nxt = 1'b1;
                end
                DIV_RUN: begin
                    if (div_out_valid) begin
                        result_nxt = f3_r[1] ? div_remainder : div_quotient;
                        state_nxt  = DONE;
                    end
                end
                DONE: begin
                    // op_valid is still high for the retiring op; never relaunch it.
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Divider handshake outputs are registered so they line up with
    // DIV_CLR / the first DIV_RUN cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count          <= '0;
            result_r       <= '0;
            div_aresetn_r  <= 1'b0;
            div_in_valid_r <= 1'b0;
        end else begin
            count          <= count_nxt;
            result_r       <= result_nxt;
            div_aresetn_r  <= div_aresetn_nxt;
            div_in_valid_r <= div_in_valid_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            opa_r <= '0;
            opb_r <= '0;
            f3_r  <= '0;
        end else if (load_ops) begin
            opa_r <= op_a;
            opb_r <= op_b;
            f3_r  <= op_funct3;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam int MUL_LATENCY = 2;
    localparam int DIV_DELAY   = 9;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_funct3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;
    logic [32:0] mul_a, mul_b;
    logic [65:0] mul_p;
    logic        div_aresetn;
    logic        div_in_valid;
    logic [31:0] div_dividend, div_divisor;
    logic        div_signed;
    logic        div_out_valid;
    logic [31:0] div_quotient, div_remainder;

    muldiv_sequencer #(.MUL_LATENCY(MUL_LATENCY)) dut (
        .clk(clk), .resetn(resetn),
        .op_valid(op_valid), .op_funct3(op_funct3), .op_a(op_a), .op_b(op_b),
        .flush(flush), .stall(stall),
        .result_valid(result_valid), .result(result),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .div_aresetn(div_aresetn), .div_in_valid(div_in_valid),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_signed(div_signed), .div_out_valid(div_out_valid),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    // Multiplier model: signed 33x33 product, two register stages.
    logic [65:0] ea, eb, prod0, mp1, mp2;
    assign ea    = {{33{mul_a[32]}}, mul_a};
    assign eb    = {{33{mul_b[32]}}, mul_b};
    assign prod0 = ea * eb;
    always @(posedge clk) begin
        mp1 <= prod0;
        mp2 <= mp1;
    end
    assign mul_p = mp2;

    // Divider model: strobes DIV_DELAY cycles after launch, cleared by div_aresetn.
    logic        dbusy = 1'b0;
    logic [3:0]  dcnt = '0;
    logic [31:0] dq = '0, dr = '0;
    logic        inject = 1'b0;
    always @(posedge clk) begin
        if (!div_aresetn) begin
            dbusy <= 1'b0;
            dcnt  <= '0;
        end else if (div_in_valid) begin
            dbusy <= 1'b1;
            dcnt  <= 4'(DIV_DELAY);
            if (div_signed) begin
                dq <= $signed(div_dividend) / $signed(div_divisor);
                dr <= $signed(div_dividend) % $signed(div_divisor);
            end else begin
                dq <= div_dividend / div_divisor;
                dr <= div_dividend % div_divisor;
            end
        end else if (dbusy) begin
            dcnt <= dcnt - 4'd1;
            if (dcnt == 4'd1) dbusy <= 1'b0;
        end
    end
    assign div_out_valid = (dbusy && dcnt == 4'd1) || inject;
    assign div_quotient  = dq;
    assign div_remainder = dr;

    int n_checks = 0;
    int n_fail   = 0;
    int n_launch = 0;
    int n_rv     = 0;
    logic [31:0] sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on result_valid, divider launch protocol.
    logic prev1_arst = 1'b0, prev2_arst = 1'b0, prev_inv = 1'b0;
    always @(negedge clk) begin
        if (resetn) begin
            if (div_in_valid) begin
                n_launch++;
                check("launch_clear_before", {30'd0, prev2_arst, prev1_arst}, 32'd2);
                check("launch_single_cycle", {31'd0, prev_inv}, 32'd0);
            end
            if (result_valid) begin
                n_rv++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result_valid: got result 0x%08h, expected none", result);
                end else begin
                    check("sb_result", result, sb.pop_front());
                end
            end
        end
        prev2_arst = prev1_arst;
        prev1_arst = div_aresetn;
        prev_inv   = div_in_valid;
    end

    // Drive is at posedge+1 of the accept cycle; returns at posedge+1 after DONE.
    task automatic wait_done(input string nm, input int exp_stall);
        int stalls = 0;
        bit timeout = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            stalls++;
            if (stalls > 200) begin
                timeout = 1;
                break;
            end
        end
        if (timeout) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: stall still high after %0d cycles, expected %0d", nm, stalls, exp_stall);
        end
        check({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({nm, "_result_valid"}, {31'd0, result_valid}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_stall, input int exp_launch);
        int l0;
        l0 = n_launch;
        op_valid  = 1'b1;
        op_funct3 = f3;
        op_a      = a;
        op_b      = b;
        sb.push_back(exp);
        wait_done(nm, exp_stall);
        check({nm, "_rv_pulse"}, {31'd0, result_valid}, 32'd0);
        check({nm, "_launches"}, 32'(n_launch - l0), 32'(exp_launch));
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stalls;
        int          launches;
    } vec_t;

    vec_t vt[18];

    initial begin
        int l0, rv0;

        vt[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 4, 0};
        vt[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4, 0};
        vt[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4, 0};
        vt[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 0};
        vt[4]  = '{3'b000, 32'h1234_5678, 32'd9,         32'hA3D7_0A38, 4, 0};
        vt[5]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4, 0};
        vt[6]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4, 0};
        vt[7]  = '{3'b100, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA, 12, 1};
        vt[8]  = '{3'b110, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 12, 1};
        vt[9]  = '{3'b101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 1, 0};
        vt[10] = '{3'b110, 32'd13,         32'd0,         32'd13,        1, 0};
        vt[11] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0};
        vt[12] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0};
        vt[13] = '{3'b101, 32'd100,        32'd7,         32'd14,        12, 1};
        vt[14] = '{3'b111, 32'd100,        32'd7,         32'd2,         12, 1};
        vt[15] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 12, 1};
        vt[16] = '{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0};
        vt[17] = '{3'b111, 32'd7,          32'd0,         32'd7,         1, 0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_div_aresetn", {31'd0, div_aresetn}, 32'd0);
        check("rst_div_in_valid", {31'd0, div_in_valid}, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_div_aresetn", {31'd0, div_aresetn}, 32'd1);

        // Table, back-to-back: each op starts in the IDLE cycle after DONE.
        for (int i = 0; i < 18; i++)
            run_op($sformatf("v%0d", i), vt[i].f3, vt[i].a, vt[i].b, vt[i].exp,
                   vt[i].stalls, vt[i].launches);
        op_valid = 1'b0;
        @(negedge clk);
        check("idle_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;

        // Flush while in DIV_RUN
        l0 = n_launch;
        op_valid  = 1'b1;
        op_funct3 = 3'b101;
        op_a      = 32'd100;
        op_b      = 32'd7;
        repeat (4) @(posedge clk);
        #1;
        flush    = 1'b1;
        op_valid = 1'b0;
        @(negedge clk);
        check("flush_stall", {31'd0, stall}, 32'd0);
        check("flush_rv", {31'd0, result_valid}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        rv0 = n_rv;
        @(negedge clk);
        check("flush_idle_stall", {31'd0, stall}, 32'd0);
        check("flush_clear_low", {31'd0, div_aresetn}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("flush_clear_release", {31'd0, div_aresetn}, 32'd1);
        @(posedge clk);
        #1;
        inject = 1'b1;
        @(posedge clk);
        #1;
        inject = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("flush_late_strobe_no_rv", 32'(n_rv - rv0), 32'd0);
        check("flush_launches", 32'(n_launch - l0), 32'd1);
        run_op("post_flush_mul", 3'b000, 32'd6, 32'd7, 32'd42, 4, 0);
        op_valid = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in MUL_WAIT, op_valid held across it
        op_valid  = 1'b1;
        op_funct3 = 3'b000;
        op_a      = 32'h0000_1234;
        op_b      = 32'd3;
        sb.push_back(32'h0000_369C);
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b0;
        sb.delete();
        #1;
        check("arst_result_valid", {31'd0, result_valid}, 32'd0);
        check("arst_result", result, 32'd0);
        check("arst_div_aresetn", {31'd0, div_aresetn}, 32'd0);
        check("arst_div_in_valid", {31'd0, div_in_valid}, 32'd0);
        check("arst_mul_a", mul_a[31:0], 32'd0);
        check("arst_mul_b", mul_b[31:0], 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sb.push_back(32'h0000_369C);
        wait_done("arst_reaccept", 4);
        check("arst_div_aresetn_back", {31'd0, div_aresetn}, 32'd1);
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Controller that runs the RV32M extension in the pipelined CPU's execute stage. It accepts one M-type operation at a time and stalls the pipeline until the result is ready. Multiplies go to a fixed-latency pipelined multiplier. Divides and remainders go to a handshaked divider core, which is cleared before each launch; divide-by-zero and signed overflow bypass the divider. It replaces fixed-count division stalling with state-tracked sequencing and supports flush.

## Interface
- MUL_LATENCY, 2: multiplier pipeline depth in cycles (0 = combinational)
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- op_valid  in  1  M-type op present in EX (held until stall drops)
- op_funct3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a, op_b  in  32  rs1, rs2 values
- flush  in  1  kill in-flight op (branch mispredict/trap)
- stall  out  1  freeze IF/ID/EX
- result_valid  out  1  result valid this cycle
- result  out  32  rd value
- mul_a, mul_b  out  33  sign- or zero-extended operands to multiplier
- mul_p  in  66  product, MUL_LATENCY cycles after operands
- div_aresetn  out  1  divider core clear, active-low
- div_in_valid  out  1  launch pulse to divider
- div_dividend, div_divisor  out  32  divider operands
- div_signed  out  1  1 for DIV/REM
- div_out_valid  in  1  divider result strobe
- div_quotient, div_remainder  in  32  divider result

## Operation
- States: IDLE, MUL_WAIT, DIV_CLR, DIV_RUN, DONE.
- IDLE accepts when op_valid & !flush: latch op_a, op_b, funct3 into operand registers. Next state depends on the op:
  - funct3[2]=0 → MUL_WAIT, count loaded with MUL_LATENCY.
  - Divide by zero (op_b==0) → DONE. DIV/DIVU result = 0xFFFFFFFF; REM/REMU result = op_a.
  - Signed overflow (funct3 100/110, op_a==0x80000000, op_b==0xFFFFFFFF) → DONE. DIV result = 0x80000000; REM result = 0.
  - Otherwise → DIV_CLR.
- Multiplier operand extension: mul_a is sign-extended for MULH and MULHSU, otherwise zero-extended. mul_b is sign-extended only for MULH. Both are driven from the operand registers.
- MUL_WAIT decrements the count each cycle. When count==0, capture mul_p[31:0] (MUL) or mul_p[63:32] (others) into result and go to DONE.
- DIV_CLR drives div_aresetn=0 for exactly one cycle, then goes to DIV_RUN.
- DIV_RUN:
  - div_in_valid=1 in the first DIV_RUN cycle only.
  - div_dividend, div_divisor and div_signed are driven from the operand registers.
  - On div_out_valid, capture div_quotient (funct3[1]=0) or div_remainder (funct3[1]=1) into result and go to DONE.
- DONE: result_valid=1, stall=0, go to IDLE. op_valid is ignored in DONE, so the retiring op is never relaunched.
- stall = (IDLE & op_valid & !flush) | MUL_WAIT | DIV_CLR | DIV_RUN. It is combinational.
- flush in any state: go to IDLE next cycle, discard result. If the state was DIV_CLR or DIV_RUN, drive div_aresetn=0 for one cycle. stall deasserts in the same cycle.
- div_out_valid outside DIV_RUN is ignored.

## Timing
- Reset values:
  - state IDLE, count 0, result 0x00000000, result_valid 0
  - div_aresetn 0, div_in_valid 0
  - operand registers 0
- div_aresetn returns to 1 on the first clock after reset release.
- MUL accepted in cycle t: MUL_WAIT runs t+1..t+1+MUL_LATENCY; DONE at t+2+MUL_LATENCY; stall high t..t+1+MUL_LATENCY.
- DIV accepted in cycle t: DIV_CLR at t+1; div_in_valid at t+2. With div_out_valid at cycle u, DONE is at u+1.
- Special-case divide: DONE at t+1, stall high for cycle t only.
- Back-to-back: a new op may be accepted in the IDLE cycle immediately after DONE.
- result holds its value until the next capture. result_valid is a one-cycle pulse.
- resetn asserted mid-operation: immediate return to reset values, with no result_valid.

## Test plan
- MUL 7×(−3) (op_b=0xFFFFFFFD), MUL_LATENCY=2: stall high 4 cycles; result 0xFFFFFFEB at DONE; result_valid high one cycle.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU(−1, 0xFFFFFFFF) → 0xFFFFFFFF.
- DIV −20/3 with divider model strobing 9 cycles after div_in_valid:
  - div_aresetn low exactly one cycle before div_in_valid
  - div_in_valid high exactly one cycle
  - result 0xFFFFFFFA (−6); REM of the same operands → 0xFFFFFFFE (−2)
- Special cases, none of which may raise div_in_valid:
  - DIVU x/0 → 0xFFFFFFFF; REM 13/0 → 13; each stalls one cycle
  - DIV 0x80000000/−1 → 0x80000000; REM of the same → 0
- Flush while in DIV_RUN: next state IDLE; div_aresetn low one cycle; a late div_out_valid produces no result_valid; the next MUL completes correctly.
- resetn asserted in MUL_WAIT: all outputs at reset values asynchronously. After release, held op_valid is reaccepted and completes normally.
